vram_wr_bridge: RTL

VRAM_WR_BRIDGE -- requirements
Module: vram_wr_bridge

---
 rtl/chr_gen_pkg.sv | 38 +++
 rtl/vram_wr_fifo.sv | 63 ++++++
 rtl/vram_wr_bridge.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/chr_gen_pkg.sv
// Shared constants for the character-generator VRAM write path: PIO command
// word bit positions, status word layout and default bridge sizes.
package chr_gen_pkg;

   localparam int unsigned C_DEPTH_DEF   = 8;
   localparam int unsigned C_AW_DEF      = 10;

   localparam int unsigned WD_DATA_MSB   = 7;
   localparam int unsigned WD_AINC_BIT   = 12;
   localparam int unsigned WD_CLR_BIT    = 13;
   localparam int unsigned WD_WTOG_BIT   = 14;

   localparam int unsigned STS_CNT_MSB   = 6;
   localparam int unsigned STS_EMPTY_BIT = 8;
   localparam int unsigned STS_FULL_BIT  = 9;
   localparam int unsigned STS_OVF_BIT   = 10;
   localparam int unsigned STS_BUSY_BIT  = 11;

   typedef struct packed {
      logic [6:0] count;
      logic       empty;
      logic       full;
      logic       ovf;
      logic       busy;
   } sts_t;

   function automatic logic [15:0] sts_pack(input sts_t s);
      logic [15:0] w;
      w                = 16'h0000;
      w[STS_CNT_MSB:0] = s.count;
      w[STS_EMPTY_BIT] = s.empty;
      w[STS_FULL_BIT]  = s.full;
      w[STS_OVF_BIT]   = s.ovf;
      w[STS_BUSY_BIT]  = s.busy;
      return w;
   endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Single-clock FIFO holding queued {address, data} VRAM writes; synchronous
// active-low reset and a synchronous flush.
module vram_wr_fifo #(
   parameter int unsigned C_DEPTH = 8,
   parameter int unsigned C_DW    = 18
) (
   input  logic                      CK_i,
   input  logic                      RST_N_i,
   input  logic                      PUSH_i,
   input  logic                      POP_i,
   input  logic                      CLR_i,
   input  logic [C_DW-1:0]           DIN_i,
   output logic [C_DW-1:0]           DOUT_o,
   output logic                      FULL_o,
   output logic                      EMPTY_o,
   output logic [$clog2(C_DEPTH):0]  COUNT_o
);
   localparam int unsigned C_PW = $clog2(C_DEPTH);
   localparam int unsigned C_CW = C_PW + 1;

   logic [C_DW-1:0] mem_q [C_DEPTH];
   logic [C_PW-1:0] wr_ptr_q;
   logic [C_PW-1:0] rd_ptr_q;
   logic [C_CW-1:0] count_q;
   logic [C_CW-1:0] count_d;

   always_comb begin
      case ({PUSH_i, POP_i})
         2'b10:   count_d = count_q + C_CW'(1);
         2'b01:   count_d = count_q - C_CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CK_i) begin
      if (!RST_N_i || CLR_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (PUSH_i) begin
            wr_ptr_q <= wr_ptr_q + C_PW'(1);
         end
         if (POP_i) begin
            rd_ptr_q <= rd_ptr_q + C_PW'(1);
         end
         count_q <= count_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge CK_i) begin
      if (PUSH_i) begin
         mem_q[wr_ptr_q] <= DIN_i;
      end
   end

   assign DOUT_o  = mem_q[rd_ptr_q];
   assign FULL_o  = (count_q == C_CW'(C_DEPTH));
   assign EMPTY_o = (count_q == '0);
   assign COUNT_o = count_q;

endmodule

// File: rtl/vram_wr_bridge.sv
// CPU PIO to VRAM write bridge: WTOG-edge requests are queued and drained as
// single-cycle VRAM writes. Define VRAM_WR_BRIDGE_BLANK_GATE_EN to drain only in blanking.
module vram_wr_bridge
   import chr_gen_pkg::*;
#(
   parameter int unsigned C_DEPTH = C_DEPTH_DEF,
   parameter int unsigned C_AW    = C_AW_DEF
) (
   input  logic            CK_i,
   input  logic            XSYS_R_i,
   input  logic [15:0]     WA_REG_i,
   input  logic [15:0]     WD_REG_i,
   input  logic            BLANK_i,
   output logic            VRAM_WE_o,
   output logic [C_AW-1:0] VRAM_WAs_o,
   output logic [7:0]      VRAM_WDs_o,
   output logic [15:0]     STS_o
);
   localparam int unsigned C_CW = $clog2(C_DEPTH) + 1;
   localparam int unsigned C_DW = C_AW + 8;

   logic [15:0]     wa_s1_q, wd_s1_q, wa_prev_q;
   logic            wtog_prev_q, s1_vld_q, primed_q;
   logic [C_AW-1:0] ptr_q, ptr_d;
   logic            ovf_q, ovf_d;
   logic            we_q;
   logic [C_AW-1:0] was_q;
   logic [7:0]      wds_q;
   logic [15:0]     sts_q;
   sts_t            sts_s;

   logic            wtog_s, ainc_s, clr_s;
   logic [7:0]      data_s;
   logic            req_s, reload_s, drain_en_s, push_s, pop_s;
   logic [C_AW-1:0] entry_addr_s;
   logic            fifo_full_s, fifo_empty_s;
   logic [C_CW-1:0] fifo_cnt_s;
   logic [C_DW-1:0] fifo_dout_s;
   logic            unused_s;

   assign wtog_s = wd_s1_q[WD_WTOG_BIT];
   assign ainc_s = wd_s1_q[WD_AINC_BIT];
   assign clr_s  = wd_s1_q[WD_CLR_BIT];
   assign data_s = wd_s1_q[WD_DATA_MSB:0];

`ifdef VRAM_WR_BRIDGE_BLANK_GATE_EN
   assign drain_en_s = BLANK_i;
   assign unused_s   = ^{wd_s1_q[15], wd_s1_q[11:8]};
`else
   assign drain_en_s = 1'b1;
   assign unused_s   = ^{wd_s1_q[15], wd_s1_q[11:8], BLANK_i};
`endif

   // A full FIFO still accepts a request when the same cycle pops; CLR wins over everything.
   always_comb begin
      req_s    = primed_q && (wtog_s != wtog_prev_q);
      reload_s = primed_q && (wa_s1_q != wa_prev_q);
      pop_s    = !fifo_empty_s && drain_en_s && !clr_s;
      push_s   = req_s && !clr_s && (!fifo_full_s || pop_s);

      if (!ainc_s) begin
         entry_addr_s = wa_s1_q[C_AW-1:0];
      end else if (reload_s) begin
         entry_addr_s = wa_s1_q[C_AW-1:0];
      end else begin
         entry_addr_s = ptr_q;
      end

      if (push_s && ainc_s) begin
         ptr_d = entry_addr_s + C_AW'(1);
      end else if (reload_s) begin
         ptr_d = wa_s1_q[C_AW-1:0];
      end else begin
         ptr_d = ptr_q;
      end

      if (clr_s) begin
         ovf_d = 1'b0;
      end else if (req_s && !push_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end

      sts_s.count = 7'(fifo_cnt_s);
      sts_s.empty = fifo_empty_s;
      sts_s.full  = fifo_full_s;
      sts_s.ovf   = ovf_q;
      sts_s.busy  = !fifo_empty_s || we_q;
   end

   always_ff @(posedge CK_i) begin
      if (!XSYS_R_i) begin
         wa_s1_q     <= 16'h0000;
         wd_s1_q     <= 16'h0000;
         wa_prev_q   <= 16'h0000;
         wtog_prev_q <= 1'b0;
         s1_vld_q    <= 1'b0;
         primed_q    <= 1'b0;
         ptr_q       <= '0;
         ovf_q       <= 1'b0;
         we_q        <= 1'b0;
         was_q       <= '0;
         wds_q       <= 8'h00;
         sts_q       <= 16'h0100;
      end else begin
         wa_s1_q     <= WA_REG_i;
         wd_s1_q     <= WD_REG_i;
         wa_prev_q   <= wa_s1_q;
         wtog_prev_q <= wtog_s;
         s1_vld_q    <= 1'b1;
         primed_q    <= s1_vld_q;
         ptr_q       <= ptr_d;
         ovf_q       <= ovf_d;
         we_q        <= pop_s;
         if (pop_s) begin
            was_q <= fifo_dout_s[C_DW-1:8];
            wds_q <= fifo_dout_s[7:0];
         end
         sts_q       <= sts_pack(sts_s);
      end
   end

   vram_wr_fifo #(
      .C_DEPTH (C_DEPTH),
      .C_DW    (C_DW)
   ) u_fifo (
      .CK_i    (CK_i),
      .RST_N_i (XSYS_R_i),
      .PUSH_i  (push_s),
      .POP_i   (pop_s),
      .CLR_i   (clr_s),
      .DIN_i   ({entry_addr_s, data_s}),
      .DOUT_o  (fifo_dout_s),
      .FULL_o  (fifo_full_s),
      .EMPTY_o (fifo_empty_s),
      .COUNT_o (fifo_cnt_s)
   );

   assign VRAM_WE_o  = we_q;
   assign VRAM_WAs_o = was_q;
   assign VRAM_WDs_o = wds_q;
   assign STS_o      = sts_q;

endmodule
